// File: rtl/bcd_score_display_counter_pkg.sv
// Shared BCD constants and helpers for the score counter and its display scan.
`define BCD_DIGIT(vec, i) vec[(i)*4 +: 4]

package bcd_score_display_counter_pkg;
  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_NINE = 4'd9;

  function automatic int unsigned score_width(input int unsigned digits);
    return digits * BCD_W;
  endfunction
endpackage

// File: rtl/bcd_score_display_counter_tick.sv
// Free-running modulo-MAX counter; TICK is high during the terminal count cycle.
module tick_divider #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned WIDTH = $clog2(MAX)
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tick_o = (cnt_q == WIDTH'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bcd_score_display_counter.sv
// BCD hit counter with saturation, high-score capture and 7-seg digit-scan strobe.
module bcd_score_display_counter
  import bcd_score_display_counter_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STROBE_DIV = 100000,
  localparam int unsigned SEL_W     = $clog2(DIGITS),
  localparam int unsigned SW        = score_width(DIGITS)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLEAR,
  input  logic             TARGET_REACHED,
  input  logic             GAME_OVER,
  output logic [SW-1:0]    SCORE,
  output logic [SW-1:0]    HIGH_SCORE,
  output logic             SATURATED,
  output logic             NEW_HIGH,
  output logic [SEL_W-1:0] STROBE,
  output logic [3:0]       DIGIT_BCD
);
  logic             tr_q;
  logic [SW-1:0]    score_q, score_d, score_inc;
  logic [SW-1:0]    high_q, high_d;
  logic             new_high_q, new_high_d;
  logic [SEL_W-1:0] strobe_q, strobe_d;
  logic [DIGITS:0]  carry;
  logic             hit;
  logic             scan_tick;

  assign hit = TARGET_REACHED & ~tr_q;

  // Ripple increment; carry out of the top digit means every digit is nine.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] d;
    assign d            = `BCD_DIGIT(score_q, g);
    assign carry[g+1]   = carry[g] & (d == BCD_NINE);
    assign `BCD_DIGIT(score_inc, g) = carry[g] ? ((d == BCD_NINE) ? 4'd0 : d + 4'd1) : d;
  end

  assign SATURATED = carry[DIGITS];

  tick_divider #(
    .MAX   (STROBE_DIV),
    .WIDTH ($clog2(STROBE_DIV))
  ) u_scan_div (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .tick_o (scan_tick)
  );

  always_comb begin
    score_d = score_q;
    if (CLEAR)                   score_d = '0;
    else if (hit && !SATURATED)  score_d = score_inc;
  end

  // Packed BCD orders the same as binary, so a plain magnitude compare suffices.
  always_comb begin
    high_d     = high_q;
    new_high_d = 1'b0;
    if (GAME_OVER && (score_q > high_q)) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end
  end

  always_comb begin
    strobe_d = strobe_q;
    if (scan_tick) begin
      if (strobe_q == SEL_W'(DIGITS - 1)) strobe_d = '0;
      else                                strobe_d = strobe_q + SEL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tr_q       <= 1'b0;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      strobe_q   <= '0;
    end else begin
      tr_q       <= TARGET_REACHED;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    DIGIT_BCD = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (strobe_q == SEL_W'(i)) DIGIT_BCD = score_q[i*BCD_W +: BCD_W];
    end
  end

  assign SCORE      = score_q;
  assign HIGH_SCORE = high_q;
  assign NEW_HIGH   = new_high_q;
  assign STROBE     = strobe_q;
endmodule

// File: tb/tb_bcd_score_display_counter.sv
// Directed bench for bcd_score_display_counter with DIGITS=4 and a DIGITS=3 scan instance.
module tb_bcd_score_display_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        tr = 1'b0;
  logic        go = 1'b0;
  logic [15:0] score, high;
  logic        sat, nh;
  logic [1:0]  strobe;
  logic [3:0]  digit;
  logic [11:0] score3, high3;
  logic        sat3, nh3;
  logic [1:0]  strobe3;
  logic [3:0]  digit3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bcd_score_display_counter #(.DIGITS(4), .STROBE_DIV(4)) dut (
    .CLK(clk), .RESET_N(rst_n), .CLEAR(clear), .TARGET_REACHED(tr), .GAME_OVER(go),
    .SCORE(score), .HIGH_SCORE(high), .SATURATED(sat), .NEW_HIGH(nh),
    .STROBE(strobe), .DIGIT_BCD(digit)
  );

  bcd_score_display_counter #(.DIGITS(3), .STROBE_DIV(4)) dut3 (
    .CLK(clk), .RESET_N(rst_n), .CLEAR(1'b0), .TARGET_REACHED(1'b0), .GAME_OVER(1'b0),
    .SCORE(score3), .HIGH_SCORE(high3), .SATURATED(sat3), .NEW_HIGH(nh3),
    .STROBE(strobe3), .DIGIT_BCD(digit3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hit();
    tr = 1'b1;
    tick();
    tr = 1'b0;
    tick();
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) hit();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_score"},  {16'h0, score}, 32'h0);
    chk({tag, "_high"},   {16'h0, high},  32'h0);
    chk({tag, "_sat"},    {31'h0, sat},   32'h0);
    chk({tag, "_nh"},     {31'h0, nh},    32'h0);
    chk({tag, "_strobe"}, {30'h0, strobe}, 32'h0);
    chk({tag, "_digit"},  {28'h0, digit}, 32'h0);
    chk({tag, "_strobe3"}, {30'h0, strobe3}, 32'h0);
  endtask

  task automatic check_scan_after_release();
    logic [1:0] exp4 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp3 [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    repeat (3) tick();
    chk("strobe_hold", {30'h0, strobe}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("strobe_step%0d", k), {30'h0, strobe}, {30'h0, exp4[k]});
      chk($sformatf("strobe3_step%0d", k), {30'h0, strobe3}, {30'h0, exp3[k]});
      if (k < 3) repeat (3) tick();
    end
  endtask

  initial begin
    logic [3:0] nib [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    // Power-on reset, released just after an edge.
    tick();
    tick();
    check_reset_state("por");
    rst_n = 1'b1;
    cyc = 0;
    check_scan_after_release();

    // Held-high input counts once, visible right after the first edge.
    tr = 1'b1;
    tick();
    chk("held_first", {16'h0, score}, 32'h0001);
    repeat (9) tick();
    tr = 1'b0;
    tick();
    chk("held_10", {16'h0, score}, 32'h0001);

    do_clear();
    chk("clear", {16'h0, score}, 32'h0000);
    hits(12);
    chk("pulses_12", {16'h0, score}, 32'h0012);

    do_clear();
    hits(999);
    chk("pre_0999", {16'h0, score}, 32'h0999);
    hit();
    chk("carry_1000", {16'h0, score}, 32'h1000);
    chk("sat_1000", {31'h0, sat}, 32'h0);
    hits(8998);
    chk("pre_9998", {16'h0, score}, 32'h9998);
    chk("sat_9998", {31'h0, sat}, 32'h0);
    hit();
    chk("score_9999", {16'h0, score}, 32'h9999);
    chk("sat_9999", {31'h0, sat}, 32'h1);
    hit();
    chk("sat_hold", {16'h0, score}, 32'h9999);

    // CLEAR beats a same-cycle hit.
    clear = 1'b1;
    tr = 1'b1;
    tick();
    clear = 1'b0;
    tr = 1'b0;
    chk("clear_prio", {16'h0, score}, 32'h0000);
    tick();
    chk("clear_prio2", {16'h0, score}, 32'h0000);

    hits(42);
    chk("score_42", {16'h0, score}, 32'h0042);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("high_42", {16'h0, high}, 32'h0042);
    chk("nh_pulse", {31'h0, nh}, 32'h1);
    tick();
    chk("nh_1cyc", {31'h0, nh}, 32'h0);

    do_clear();
    chk("clear_keeps_high", {16'h0, high}, 32'h0042);
    hits(42);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("equal_nh", {31'h0, nh}, 32'h0);
    chk("equal_high", {16'h0, high}, 32'h0042);
    tick();
    hit();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("high_43", {16'h0, high}, 32'h0043);
    chk("nh_43", {31'h0, nh}, 32'h1);
    tick();

    // GAME_OVER and hit together: compare uses the score before increment.
    go = 1'b1;
    tr = 1'b1;
    tick();
    go = 1'b0;
    tr = 1'b0;
    chk("go_hit_score", {16'h0, score}, 32'h0044);
    chk("go_hit_high", {16'h0, high}, 32'h0043);
    chk("go_hit_nh", {31'h0, nh}, 32'h0);
    tick();

    do_clear();
    hits(1234);
    chk("score_1234", {16'h0, score}, 32'h1234);
    for (int k = 0; k < 16; k++) begin
      int s;
      s = (cyc / 4) % 4;
      chk($sformatf("scan_strobe%0d", k), {30'h0, strobe}, s);
      chk($sformatf("scan_digit%0d", k), {28'h0, digit}, {28'h0, nib[s]});
      chk($sformatf("scan_strobe3_%0d", k), {30'h0, strobe3}, (cyc / 4) % 3);
      tick();
    end

    // Asynchronous reset mid-run clears before the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    tick();
    rst_n = 1'b1;
    cyc = 0;
    check_scan_after_release();
    hit();
    chk("post_rst_hit", {16'h0, score}, 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
